iram_mc: RTL

IRAM_MC -- requirements
Module: iram_mc

---
 rtl/iram_pkg.sv | 13 +
 rtl/iram_loader.sv | 72 +++++++
 rtl/iram_mc.sv | 75 +++++++
 3 files changed

// File: rtl/iram_pkg.sv
// Shared definitions for the multi-core instruction RAM: loader FSM states and
// default geometry.
package iram_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int NCORES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/iram_loader.sv
// Program-load sequencer: session FSM, write pointer and accepted-word counter.
// Fetches are only permitted while this block reports idle.
module iram_loader
  import iram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   ld_count,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              fetch_ok
);
  localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] WPTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [ADDR_W-1:0] wptr_q;
  logic [ADDR_W:0]   cnt_q;
  logic              accept_s;

  assign accept_s = ld_valid && (state_q == ST_LOAD);

  // Session FSM with write pointer and saturating word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ld_start) begin
            state_q <= ST_LOAD;
            wptr_q  <= ld_base;
            cnt_q   <= '0;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            wptr_q <= wptr_q + WPTR_ONE;
            if (cnt_q != CNT_MAX) begin
              cnt_q <= cnt_q + CNT_ONE;
            end
            if (ld_last) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ld_ready  = (state_q == ST_LOAD);
  assign ld_busy   = (state_q == ST_LOAD) || (state_q == ST_DONE);
  assign load_done = (state_q == ST_DONE);
  assign fetch_ok  = (state_q == ST_IDLE);
  assign ld_count  = cnt_q;
  assign wr_en     = accept_s;
  assign wr_addr   = wptr_q;
endmodule

// File: rtl/iram_mc.sv
// Multi-core instruction RAM: one loader write port and NCORES independent
// registered read ports that are blocked while a load session is active.
module iram_mc
  import iram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NCORES = NCORES_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_start,
  input  logic [ADDR_W-1:0]        ld_base,
  input  logic                     ld_valid,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic                     ld_last,
  output logic                     ld_ready,
  output logic                     ld_busy,
  output logic                     load_done,
  output logic [ADDR_W:0]          ld_count,
  input  logic [NCORES-1:0]        core_en,
  input  logic [NCORES*ADDR_W-1:0] core_addr,
  output logic [NCORES*DATA_W-1:0] core_data,
  output logic [NCORES-1:0]        core_valid
);
  logic [DATA_W-1:0]        mem_q [0:(1<<ADDR_W)-1];
  logic [NCORES*DATA_W-1:0] core_data_q;
  logic [NCORES-1:0]        core_valid_q;
  logic                     wr_en_s;
  logic [ADDR_W-1:0]        wr_addr_s;
  logic                     fetch_ok_s;

  iram_loader #(.ADDR_W(ADDR_W)) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_start  (ld_start),
    .ld_base   (ld_base),
    .ld_valid  (ld_valid),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .ld_busy   (ld_busy),
    .load_done (load_done),
    .ld_count  (ld_count),
    .wr_en     (wr_en_s),
    .wr_addr   (wr_addr_s),
    .fetch_ok  (fetch_ok_s)
  );

  // Array is deliberately not reset so a program survives a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_addr_s] <= ld_data;
    end
  end

  // Per-core read registers; data holds whenever a fetch is not served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_data_q  <= '0;
      core_valid_q <= '0;
    end else begin
      for (int i = 0; i < NCORES; i++) begin
        if (fetch_ok_s && core_en[i]) begin
          core_data_q[i*DATA_W +: DATA_W] <= mem_q[core_addr[i*ADDR_W +: ADDR_W]];
          core_valid_q[i]                 <= 1'b1;
        end else begin
          core_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign core_data  = core_data_q;
  assign core_valid = core_valid_q;
endmodule
